// File: rtl/extract_dig_pkg.sv
// Shared types and constants for the binary-to-BCD digit extractor.
package extract_dig_pkg;
   localparam int          IN_W           = 8;
   localparam logic [3:0]  BCD_ADD_THRESH = 4'd5;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      DONE    = 2'd2
   } state_t;
endpackage

// File: rtl/extract_dig_bcd_add3.sv
// Double-dabble correction cell: add 3 to a BCD nibble that is 5 or more.
module bcd_add3
   import extract_dig_pkg::*;
(
   input  logic [3:0] nib,
   output logic [3:0] adj
);
   assign adj = (nib >= BCD_ADD_THRESH) ? nib + 4'd3 : nib;
endmodule

// File: rtl/extract_dig.sv
// Iterative 8-bit binary to 3-digit BCD converter (double dabble, MSB first).
//
// state   | meaning
// IDLE    | ready; accept digit_1 on in_valid
// CONVERT | eight correct-and-shift steps, one per input bit
// DONE    | publish digits, pulse out_valid, return to IDLE
module extract_dig
   import extract_dig_pkg::*;
#(
   parameter int IN_W = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [IN_W-1:0] digit_1,
   output logic [1:0]      hundreds_place,
   output logic [3:0]      tenths_place,
   output logic [3:0]      ones_place,
   output logic            over_99,
   output logic            out_valid
);
   localparam int SR_W = IN_W + 12;

   state_t          state;
   logic [2:0]      cnt;
   logic [SR_W-1:0] sreg;
   logic [3:0]      h_adj, t_adj, o_adj;
   logic [SR_W-1:0] sreg_adj;

   // Shift register layout: {hundreds, tens, ones, remaining binary bits}
   bcd_add3 u_add3_h (.nib(sreg[IN_W+11:IN_W+8]), .adj(h_adj));
   bcd_add3 u_add3_t (.nib(sreg[IN_W+7:IN_W+4]),  .adj(t_adj));
   bcd_add3 u_add3_o (.nib(sreg[IN_W+3:IN_W]),    .adj(o_adj));

   assign sreg_adj = {h_adj, t_adj, o_adj, sreg[IN_W-1:0]};
   assign in_ready = (state == IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         cnt            <= '0;
         sreg           <= '0;
         hundreds_place <= '0;
         tenths_place   <= '0;
         ones_place     <= '0;
         over_99        <= 1'b0;
         out_valid      <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  sreg  <= {12'd0, digit_1};
                  cnt   <= '0;
                  state <= CONVERT;
               end
            end
            CONVERT: begin
               sreg <= {sreg_adj[SR_W-2:0], 1'b0};
               cnt  <= cnt + 3'd1;
               if (cnt == 3'(IN_W-1))
                  state <= DONE;
            end
            DONE: begin
               hundreds_place <= sreg[IN_W+9:IN_W+8];
               tenths_place   <= sreg[IN_W+7:IN_W+4];
               ones_place     <= sreg[IN_W+3:IN_W];
               over_99        <= (sreg[IN_W+9:IN_W+8] != 2'd0);
               out_valid      <= 1'b1;
               state          <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_extract_dig.sv
// Self-checking bench for extract_dig: arithmetic model plus directed literal checks.
module tb_extract_dig;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] digit_1 = 8'd0;
   logic       in_ready;
   logic [1:0] hundreds_place;
   logic [3:0] tenths_place;
   logic [3:0] ones_place;
   logic       over_99;
   logic       out_valid;

   int n_chk  = 0;
   int n_fail = 0;

   extract_dig #(.IN_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .digit_1(digit_1), .hundreds_place(hundreds_place), .tenths_place(tenths_place),
      .ones_place(ones_place), .over_99(over_99), .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a request takes 9 edges from acceptance to published result.
   int m_busy, m_val, m_h, m_t, m_o, m_ov, m_valid;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 0; m_val <= 0; m_valid <= 0;
         m_h <= 0; m_t <= 0; m_o <= 0; m_ov <= 0;
      end else begin
         m_valid <= 0;
         if (m_busy == 0) begin
            if (in_valid) begin
               m_val  <= int'(digit_1);
               m_busy <= 9;
            end
         end else begin
            m_busy <= m_busy - 1;
            if (m_busy == 1) begin
               m_h     <= m_val / 100;
               m_t     <= (m_val / 10) % 10;
               m_o     <= m_val % 10;
               m_ov    <= (m_val > 99) ? 1 : 0;
               m_valid <= 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("in_ready", int'(in_ready), (m_busy == 0) ? 1 : 0);
         chk("out_valid", int'(out_valid), m_valid);
         chk("hundreds", int'(hundreds_place), m_h);
         chk("tens", int'(tenths_place), m_t);
         chk("ones", int'(ones_place), m_o);
         chk("over_99", int'(over_99), m_ov);
         chk("tens_le_9", (tenths_place <= 4'd9) ? 1 : 0, 1);
         chk("ones_le_9", (ones_place <= 4'd9) ? 1 : 0, 1);
      end
   end

   // One request; checks latency, hold of previous result, and literal digits.
   task automatic conv(input int v, input int eh, input int et, input int eo, input int eov,
                       input int ph, input int pt, input int po);
      int n;
      @(negedge clk);
      digit_1  = 8'(v);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      digit_1  = ~8'(v);
      n = 0;
      while (!out_valid && n < 20) begin
         chk("hold_h", int'(hundreds_place), ph);
         chk("hold_t", int'(tenths_place), pt);
         chk("hold_o", int'(ones_place), po);
         @(posedge clk);
         #1;
         n++;
      end
      chk("latency", n, 9);
      chk("lit_h", int'(hundreds_place), eh);
      chk("lit_t", int'(tenths_place), et);
      chk("lit_o", int'(ones_place), eo);
      chk("lit_ov", int'(over_99), eov);
      @(posedge clk);
      #1;
      chk("pulse_width", int'(out_valid), 0);
   endtask

   initial begin
      int w;
      #12;
      chk("rst_h", int'(hundreds_place), 0);
      chk("rst_t", int'(tenths_place), 0);
      chk("rst_o", int'(ones_place), 0);
      chk("rst_ov", int'(over_99), 0);
      chk("rst_valid", int'(out_valid), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", int'(in_ready), 1);

      conv(95, 0, 9, 5, 0, 0, 0, 0);
      conv(25, 0, 2, 5, 0, 0, 9, 5);
      conv(0, 0, 0, 0, 0, 0, 2, 5);
      conv(99, 0, 9, 9, 0, 0, 0, 0);
      conv(100, 1, 0, 0, 1, 0, 9, 9);
      conv(255, 2, 5, 5, 1, 1, 0, 0);

      // Exhaustive sweep with in_valid held high.
      for (int v = 0; v < 256; v++) begin
         @(negedge clk);
         w = 0;
         while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
         end
         if (w >= 20) chk("sweep_timeout", 0, 1);
         digit_1  = 8'(v);
         in_valid = 1'b1;
         @(posedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0;
      repeat (12) @(negedge clk);
      chk("sweep_last_h", int'(hundreds_place), 2);
      chk("sweep_last_o", int'(ones_place), 5);

      // Abort mid-conversion with reset, then convert normally.
      @(negedge clk);
      digit_1  = 8'd200;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_h", int'(hundreds_place), 0);
      chk("abort_t", int'(tenths_place), 0);
      chk("abort_o", int'(ones_place), 0);
      chk("abort_ov", int'(over_99), 0);
      chk("abort_valid", int'(out_valid), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      conv(37, 0, 3, 7, 0, 0, 0, 0);

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/extract_dig.md
EXTRACT_DIG -- requirements
Module: extract_dig

Interface
REQ-001 Parameter IN_W, default 8: binary input width; only 8 is required to be supported.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  request conversion of digit_1 this cycle.
REQ-005 in_ready  output  1  high when a new conversion can be accepted (idle).
REQ-006 digit_1  input  8  unsigned binary value, 0..255.
REQ-007 hundreds_place  output  2  BCD hundreds digit, 0..2.
REQ-008 tenths_place  output  4  BCD tens digit, 0..9.
REQ-009 ones_place  output  4  BCD ones digit, 0..9.
REQ-010 over_99  output  1  high when the converted value is greater than 99.
REQ-011 out_valid  output  1  one-cycle pulse marking a new result.

Function
REQ-012 The conversion SHALL be digit_1 = 100*hundreds_place + 10*tenths_place + ones_place, exact for all 256 inputs.
REQ-013 Algorithm: iterative shift-add-3 (double dabble), one input bit per cycle, MSB first; add 3 to any BCD nibble that is >= 5 before each shift.
REQ-014 States: IDLE, CONVERT, DONE.
REQ-015 IDLE -> CONVERT when in_valid && in_ready; digit_1 is captured on that edge.
REQ-016 CONVERT runs exactly 8 cycles, driven by a 3-bit bit counter.
REQ-017 CONVERT -> DONE after the 8th shift.
REQ-018 DONE -> IDLE after one cycle.
REQ-019 Latency: if accepted at edge N, out_valid is high for exactly the cycle after edge N+9 and the result registers update on edge N+9.
REQ-020 in_ready = 1 only in IDLE; in_valid is ignored outside IDLE, so a changing digit_1 mid-conversion does not affect the result.
REQ-021 Result outputs and over_99 hold their last value until the next conversion completes; they never show intermediate values.
REQ-022 over_99 = (hundreds_place != 0), registered together with the digits.
REQ-023 Back-to-back requests: in_valid held high gives one conversion per 10 cycles.
REQ-024 Boundaries:
- 0 -> 0/0/0.
- 99 -> 0/9/9, over_99 = 0.
- 100 -> 1/0/0, over_99 = 1.
- 255 -> 2/5/5.
- No nibble may ever exceed 9 at the outputs.

Reset
REQ-025 While rst_n = 0, the block SHALL set:
- state = IDLE, bit counter = 0, shift register = 0;
- hundreds_place = 0, tenths_place = 0, ones_place = 0;
- over_99 = 0, out_valid = 0;
- in_ready = 1 once released.
REQ-026 Reset asserted mid-conversion SHALL abort the conversion with no out_valid pulse; the first request after release converts normally.

Structure
REQ-027 A shared package SHALL hold:
- the state enum (IDLE, CONVERT, DONE);
- constants IN_W = 8 and BCD_ADD_THRESH = 5.
REQ-028 One sub-module, bcd_add3 (4-bit in, 4-bit out, combinational add-3-if-≥5), SHALL be instantiated once per BCD nibble.

Verification
REQ-029 Drive digit_1 = 95, pulse in_valid -> after 9 edges: out_valid = 1, tenths_place = 9, ones_place = 5, hundreds_place = 0, over_99 = 0.
REQ-030 Drive digit_1 = 25 -> tenths_place = 2, ones_place = 5; previous result (9/5) is held until out_valid.
REQ-031 Apply 0, 99, 100, 255 -> 0/0/0, 0/9/9 (over_99 = 0), 1/0/0 (over_99 = 1), 2/5/5.
REQ-032 Exhaustive sweep 0..255 with in_valid held high -> every result matches REQ-012, out_valid every 10 cycles, in_ready low during CONVERT and DONE.
REQ-033 Assert rst_n = 0 in the 4th CONVERT cycle of a request for 200 -> all outputs 0 immediately, no out_valid; after release, a request for 37 -> 0/3/7.
